// File: rtl/log_seq_pkg.sv
// Shared state encoding and default geometry for the sample-logging sequencer.
package log_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_LOGGING = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DEPTH  = 32000;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/log_rd_port.sv
// Host read-back port: single-outstanding request, range/state rejection and
// a RD_LATENCY-deep pending pipeline that times the RAM data capture (RD_LATENCY >= 1).
module log_rd_port
    import log_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_host_ok,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_ram_data,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_rd_err,
    output logic              o_busy
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [RD_LATENCY:0] pipe_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                pending;
    logic                in_range;
    logic                accept;

    assign pending  = |pipe_q;
    assign in_range = {1'b0, i_rd_addr} < DEPTH_LIM;
    assign accept   = i_rd_req && i_host_ok && !pending && in_range;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            pipe_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pipe_q <= {pipe_q[RD_LATENCY-1:0], accept};
            err_q  <= i_rd_req && !accept;
            if (accept)
                addr_q <= i_rd_addr;
            if (pipe_q[RD_LATENCY])
                data_q <= i_ram_data;
        end
    end

    // RAM data is forwarded in its valid cycle and held in data_q afterwards.
    assign o_rd_en    = pipe_q[0];
    assign o_rd_addr  = addr_q;
    assign o_rd_valid = pipe_q[RD_LATENCY];
    assign o_rd_data  = o_rd_valid ? i_ram_data : data_q;
    assign o_rd_err   = err_q;
    assign o_busy     = pending || accept;

endmodule

// File: rtl/log_sequencer.sv
// Capture sequencer for the sample-logging BlockRAM: arm/trigger/log FSM,
// write address counter and host read-back port.
//
// state      | meaning
// ST_IDLE    | no capture; host reads allowed
// ST_ARMED   | capture armed, waiting for i_trigger
// ST_LOGGING | each valid sample written at o_count
// ST_DONE    | buffer full, o_done set; host reads allowed
module log_sequencer
    import log_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_trig_mode,
    input  logic              i_trigger,
    input  logic              i_sample_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_ram_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_rd_err,
    output logic [1:0]        o_status,
    output logic              o_done,
    output logic [ADDR_W:0]   o_count
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    state_t          state_q, state_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            done_q, done_d;
    logic            host_ok;
    logic            rd_busy;
    logic            arm_ok;
    logic            wr_en;

    assign host_ok = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wr_en   = (state_q == ST_LOGGING) && i_sample_valid;
    // Arming is refused while a read is in flight so RAM ports never collide.
    assign arm_ok  = i_arm && !i_abort && !rd_busy;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_ok) begin
                    count_d = '0;
                    done_d  = 1'b0;
                    state_d = i_trig_mode ? ST_ARMED : ST_LOGGING;
                end
            end
            ST_ARMED: begin
                if (i_abort)
                    state_d = ST_IDLE;
                else if (i_trigger)
                    state_d = ST_LOGGING;
            end
            ST_LOGGING: begin
                if (wr_en)
                    count_d = count_q + 1'b1;
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (wr_en && (count_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    log_rd_port #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_port (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_host_ok  (host_ok),
        .i_rd_req   (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .i_ram_data (i_ram_data),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_rd_err   (o_rd_err),
        .o_busy     (rd_busy)
    );

    assign o_wr_en   = wr_en;
    assign o_wr_addr = count_q[ADDR_W-1:0];
    assign o_status  = state_q;
    assign o_done    = done_q;
    assign o_count   = count_q;

endmodule

// File: tb/tb_log_sequencer.sv
// Bench for log_sequencer: two instances (RD_LATENCY 1 and 2) driven with shared
// directed and random stimulus, checked each cycle against a cycle-level model.
module tb_log_sequencer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;

    logic        clock = 1'b0;
    logic        i_reset, i_arm, i_abort, i_trig_mode, i_trigger, i_sample_valid, i_rd_req;
    logic [3:0]  i_rd_addr;

    logic        wr_en    [2];
    logic [3:0]  wr_addr  [2];
    logic        rd_en    [2];
    logic [3:0]  rd_addr  [2];
    logic [31:0] ram_data [2];
    logic [31:0] rd_data  [2];
    logic        rd_valid [2];
    logic        rd_err   [2];
    logic [1:0]  status   [2];
    logic        done     [2];
    logic [4:0]  count    [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    log_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32), .RD_LATENCY(1)) u_lat1 (
        .clock(clock), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_trig_mode(i_trig_mode), .i_trigger(i_trigger), .i_sample_valid(i_sample_valid),
        .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_ram_data(ram_data[0]),
        .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .o_rd_err(rd_err[0]),
        .o_status(status[0]), .o_done(done[0]), .o_count(count[0]));

    log_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(32), .RD_LATENCY(2)) u_lat2 (
        .clock(clock), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_trig_mode(i_trig_mode), .i_trigger(i_trigger), .i_sample_valid(i_sample_valid),
        .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_ram_data(ram_data[1]),
        .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .o_rd_err(rd_err[1]),
        .o_status(status[1]), .o_done(done[1]), .o_count(count[1]));

    function automatic logic [31:0] mem_word(input logic [3:0] a);
        return 32'hA5A5_0000 | {28'd0, a};
    endfunction

    // RAM models: registered output, one and two stages; garbage when not read.
    logic [31:0] r1_q, r2_a, r2_b;
    always @(posedge clock) begin
        r1_q <= rd_en[0] ? mem_word(rd_addr[0]) : 32'hDEAD_0001;
        r2_a <= rd_en[1] ? mem_word(rd_addr[1]) : 32'hDEAD_0002;
        r2_b <= r2_a;
    end
    assign ram_data[0] = r1_q;
    assign ram_data[1] = r2_b;

    // Reference model: 0 IDLE, 1 ARMED, 2 LOGGING, 3 DONE; reads tracked by accept cycle.
    int          cyc = 0;
    int          lat      [2] = '{1, 2};
    int          m_state  [2];
    int          m_count  [2];
    int          m_done   [2];
    int          acc_cyc  [2];
    logic [3:0]  acc_addr [2];
    int          err_cyc  [2];
    logic [31:0] m_data   [2];

    task automatic model_reset(input int k);
        m_state[k]  = 0;
        m_count[k]  = 0;
        m_done[k]   = 0;
        acc_cyc[k]  = -100;
        acc_addr[k] = 4'd0;
        err_cyc[k]  = -100;
        m_data[k]   = 32'd0;
    endtask

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s[lat%0d] cyc %0d: observed %0h expected %0h", tag, k + 1, cyc, obs, exp);
        end
    endtask

    task automatic model_advance(input int k);
        bit pending, accept, arm_ok, wr;
        pending = (cyc >= acc_cyc[k] + 1) && (cyc <= acc_cyc[k] + 1 + lat[k]);
        accept  = i_rd_req && (m_state[k] == 0 || m_state[k] == 3) && !pending && (int'(i_rd_addr) < DEPTH);
        if (i_rd_req && !accept) err_cyc[k] = cyc + 1;
        if (accept) begin
            acc_cyc[k]  = cyc;
            acc_addr[k] = i_rd_addr;
        end
        arm_ok = i_arm && !i_abort && !pending && !accept;
        wr     = (m_state[k] == 2) && i_sample_valid;
        case (m_state[k])
            0, 3: if (arm_ok) begin
                m_count[k] = 0;
                m_done[k]  = 0;
                m_state[k] = i_trig_mode ? 1 : 2;
            end
            1: if (i_abort) m_state[k] = 0; else if (i_trigger) m_state[k] = 2;
            default: begin
                if (wr) m_count[k]++;
                if (i_abort) m_state[k] = 0;
                else if (m_count[k] == DEPTH) begin
                    m_state[k] = 3;
                    m_done[k]  = 1;
                end
            end
        endcase
    endtask

    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            bit exp_rd_en, exp_valid;
            exp_rd_en = (cyc == acc_cyc[k] + 1);
            exp_valid = (cyc == acc_cyc[k] + 1 + lat[k]);
            if (exp_valid) m_data[k] = mem_word(acc_addr[k]);
            check("status",   k, 32'(status[k]),   32'(m_state[k]));
            check("count",    k, 32'(count[k]),    32'(m_count[k]));
            check("done",     k, 32'(done[k]),     32'(m_done[k]));
            check("wr_en",    k, 32'(wr_en[k]),    32'((m_state[k] == 2) && i_sample_valid));
            check("wr_addr",  k, 32'(wr_addr[k]),  32'(m_count[k] % 16));
            check("rd_en",    k, 32'(rd_en[k]),    32'(exp_rd_en));
            if (exp_rd_en) check("rd_addr", k, 32'(rd_addr[k]), 32'(acc_addr[k]));
            check("rd_valid", k, 32'(rd_valid[k]), 32'(exp_valid));
            check("rd_data",  k, rd_data[k],       m_data[k]);
            check("rd_err",   k, 32'(rd_err[k]),   32'(cyc == err_cyc[k]));
            check("no_wr_rd", k, 32'(wr_en[k] && rd_en[k]), 32'd0);
            if (i_reset) model_reset(k);
            else model_advance(k);
        end
        cyc++;
        @(negedge clock);
        i_reset   = 1'b0;
        i_arm     = 1'b0;
        i_abort   = 1'b0;
        i_trigger = 1'b0;
        i_rd_req  = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_arm = 1'b0; i_abort = 1'b0; i_trig_mode = 1'b0;
        i_trigger = 1'b0; i_sample_valid = 1'b0; i_rd_req = 1'b0; i_rd_addr = 4'd0;
        model_reset(0);
        model_reset(1);
        @(negedge clock);

        // reset state
        i_reset = 1'b1; step();
        check("rst_status", 0, 32'(status[0]), 32'd0);
        check("rst_count",  0, 32'(count[0]),  32'd0);
        check("rst_rddata", 0, rd_data[0],     32'd0);
        step();

        // immediate capture fills the buffer and stops
        i_trig_mode = 1'b0; i_sample_valid = 1'b1; i_arm = 1'b1; step();
        check("imm_status", 0, 32'(status[0]), 32'd2);
        repeat (10) step();
        check("fill_status", 0, 32'(status[0]), 32'd3);
        check("fill_done",   0, 32'(done[0]),   32'd1);
        check("fill_count",  1, 32'(count[1]),  32'd8);

        // triggered capture: no writes until the cycle after the trigger
        i_trig_mode = 1'b1; i_arm = 1'b1; step();
        check("arm_clears_done", 0, 32'(done[0]), 32'd0);
        repeat (4) step();
        i_trigger = 1'b1; step();
        check("first_wr_en",   0, 32'(wr_en[0]),   32'd1);
        check("first_wr_addr", 0, 32'(wr_addr[0]), 32'd0);
        repeat (10) step();

        // abort with simultaneous arm after three writes
        i_trig_mode = 1'b0; i_arm = 1'b1; step();
        repeat (3) step();
        i_sample_valid = 1'b0; i_abort = 1'b1; i_arm = 1'b1; step();
        check("abort_status", 0, 32'(status[0]), 32'd0);
        check("abort_count",  0, 32'(count[0]),  32'd3);
        check("abort_done",   0, 32'(done[0]),   32'd0);
        repeat (2) step();
        check("no_rearm", 1, 32'(status[1]), 32'd0);

        // read-back in DONE for both latencies
        i_sample_valid = 1'b1; i_arm = 1'b1; step();
        repeat (9) step();
        i_sample_valid = 1'b0;
        i_rd_req = 1'b1; i_rd_addr = 4'd5; step();
        check("rd5_en",   0, 32'(rd_en[0]),   32'd1);
        check("rd5_addr", 1, 32'(rd_addr[1]), 32'd5);
        step();
        check("rd5_valid_l1", 0, 32'(rd_valid[0]), 32'd1);
        check("rd5_data_l1",  0, rd_data[0],       32'hA5A5_0005);
        step();
        check("rd5_valid_l2", 1, 32'(rd_valid[1]), 32'd1);
        check("rd5_data_l2",  1, rd_data[1],       32'hA5A5_0005);
        step();

        // rejections: out of range, back-to-back, during logging
        i_rd_req = 1'b1; i_rd_addr = 4'd8; step();
        check("oor_err", 0, 32'(rd_err[0]), 32'd1);
        check("oor_en",  0, 32'(rd_en[0]),  32'd0);
        step();
        i_rd_req = 1'b1; i_rd_addr = 4'd2; step();
        i_rd_req = 1'b1; i_rd_addr = 4'd3; step();
        check("b2b_err", 1, 32'(rd_err[1]), 32'd1);
        repeat (4) step();
        i_sample_valid = 1'b1; i_arm = 1'b1; step();
        i_rd_req = 1'b1; i_rd_addr = 4'd1; step();
        check("log_err", 0, 32'(rd_err[0]), 32'd1);
        check("log_en",  0, 32'(rd_en[0]),  32'd0);

        // reset mid-capture and mid-read
        repeat (2) step();
        i_reset = 1'b1; step();
        check("rstlog_status", 0, 32'(status[0]), 32'd0);
        check("rstlog_count",  0, 32'(count[0]),  32'd0);
        check("rstlog_wr_en",  0, 32'(wr_en[0]),  32'd0);
        i_sample_valid = 1'b0;
        i_rd_req = 1'b1; i_rd_addr = 4'd4; step();
        i_reset = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            check("rstrd_valid", 1, 32'(rd_valid[1]), 32'd0);
            step();
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            i_sample_valid = ($urandom % 4) != 0;
            i_arm          = ($urandom % 12) == 0;
            i_trig_mode    = 1'($urandom % 2);
            i_abort        = ($urandom % 50) == 0;
            i_trigger      = ($urandom % 8) == 0;
            i_rd_req       = ($urandom % 5) == 0;
            i_rd_addr      = 4'($urandom % 12);
            i_reset        = ($urandom % 500) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
